// File: rtl/vga_interface_pkg.sv
// Shared VGA 640x480@60 timing constants, bus widths and colour payload type
// for the display-side pixel interface.
package vga_interface_pkg;

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned ADDRH_W  = 10;
    localparam int unsigned ADDRV_W  = 9;
    localparam int unsigned DIV_W    = 4;

    localparam int unsigned VGA_CLK_DIV   = 4;
    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    localparam int unsigned VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam int unsigned VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    // 3-3-2 colour as wired to the resistor DAC
    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    localparam rgb332_t COLOUR_BLACK = '0;

    function automatic logic in_span(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_interface_if.sv
// Pixel-address / colour bus between the VGA timing block and the renderer,
// plus the connector-side sync and colour pins.
interface vga_interface_if;
    import vga_interface_pkg::*;

    logic [ADDRH_W-1:0] addrh;
    logic [ADDRV_W-1:0] addrv;
    rgb332_t            colour_in;
    rgb332_t            colour_out;
    logic               hs;
    logic               vs;
    logic               frame_start;

    modport master (
        output addrh, addrv, colour_out, hs, vs, frame_start,
        input  colour_in
    );

    modport slave (
        input  addrh, addrv, colour_out, hs, vs, frame_start,
        output colour_in
    );
endinterface

// File: rtl/vga_wrap_counter.sv
// Enable-gated up-counter that wraps from MAX back to zero; wrap_c flags the
// enabled cycle on which the wrap happens.
module vga_wrap_counter #(
    parameter int unsigned MAX   = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap_c
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    always_comb wrap_c = en && (cnt == MAX_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap_c ? '0 : cnt + WIDTH'(1);
        end
    end
endmodule

// File: rtl/vga_interface.sv
// VGA timing generator: drives pixel addresses to the renderer, returns its
// colour one pixel tick later with matching syncs, blanked outside the frame.
module vga_interface
    import vga_interface_pkg::*;
#(
    parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK
) (
    input  logic            clk,
    input  logic            rst,
    vga_interface_if.master bus
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_VIS_LIM = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_LIM = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_FIRST  = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST  = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             div_wrap_c;
    logic             h_wrap_c;
    logic             v_wrap_c;
    logic             pix_tick_c;
    logic             line_end_c;

    logic h_vis_c;
    logic v_vis_c;
    logic hs_c;
    logic vs_c;

    logic vis0;
    logic hs0;
    logic vs0;

    vga_wrap_counter #(.MAX(CLK_DIV - 1), .WIDTH(DIV_W)) u_div (
        .clk    (clk),
        .rst    (rst),
        .en     (1'b1),
        .cnt    (div_cnt),
        .wrap_c (div_wrap_c)
    );

    vga_wrap_counter #(.MAX(H_TOTAL - 1), .WIDTH(CNT_W)) u_hcnt (
        .clk    (clk),
        .rst    (rst),
        .en     (div_wrap_c),
        .cnt    (hcnt),
        .wrap_c (h_wrap_c)
    );

    vga_wrap_counter #(.MAX(V_TOTAL - 1), .WIDTH(CNT_W)) u_vcnt (
        .clk    (clk),
        .rst    (rst),
        .en     (line_end_c),
        .cnt    (vcnt),
        .wrap_c (v_wrap_c)
    );

    // Window compares on the live counters, captured by stage 0
    always_comb begin
        pix_tick_c = (div_cnt == DIV_LAST);
        line_end_c = pix_tick_c && h_wrap_c;
        h_vis_c    = (hcnt < H_VIS_LIM);
        v_vis_c    = (vcnt < V_VIS_LIM);
        hs_c       = !in_span(hcnt, HS_FIRST, HS_LAST);
        vs_c       = !in_span(vcnt, VS_FIRST, VS_LAST);
    end

    // Stage 0: addresses out to the renderer, visibility and syncs held alongside
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.addrh <= '0;
            bus.addrv <= '0;
            vis0      <= 1'b0;
            hs0       <= 1'b1;
            vs0       <= 1'b1;
        end else if (pix_tick_c) begin
            bus.addrh <= h_vis_c ? ADDRH_W'(hcnt) : '0;
            bus.addrv <= v_vis_c ? vcnt[ADDRV_W-1:0] : '0;
            vis0      <= h_vis_c && v_vis_c;
            hs0       <= hs_c;
            vs0       <= vs_c;
        end
    end

    // Stage 1: renderer colour meets its syncs at the pins; frame pulse follows the 0,0 reload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.colour_out  <= COLOUR_BLACK;
            bus.hs          <= 1'b1;
            bus.vs          <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= v_wrap_c;
            if (pix_tick_c) begin
                bus.colour_out <= vis0 ? bus.colour_in : COLOUR_BLACK;
                bus.hs         <= hs0;
                bus.vs         <= vs0;
            end
        end
    end
endmodule

// File: tb/tb_vga_interface.sv
// Bench for vga_interface: full-size timing at CLK_DIV 4 and 2, plus a tiny
// geometry instance for whole-frame behaviour.
module tb_vga_interface;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    vga_interface_if a_if ();
    vga_interface_if b_if ();
    vga_interface_if c_if ();

    // Renderer models: address-derived colour for the full-size units, white for the tiny one
    assign a_if.colour_in = a_if.addrh[7:0] ^ a_if.addrv[7:0] ^ 8'h3C;
    assign b_if.colour_in = b_if.addrh[7:0] ^ b_if.addrv[7:0] ^ 8'h3C;
    assign c_if.colour_in = 8'hFF;

    vga_interface u_a (.clk(clk), .rst(rst), .bus(a_if));

    vga_interface #(.CLK_DIV(2)) u_b (.clk(clk), .rst(rst), .bus(b_if));

    // 15 ticks per line, 8 lines per frame, 240 CLK per frame
    vga_interface #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_c (.clk(clk), .rst(rst), .bus(c_if));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // k = CLK edges after reset release; sample 1 time unit after that edge
    typedef struct {
        int dut;
        int k;
        int addrh;
        int addrv;
        int colour;
        int hs;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    // Whole-frame statistics of the tiny instance since the last reset release
    int c_pos = 0;
    int c_fs_cnt = 0, c_fs_first = -1, c_fs_second = -1;
    int c_max_h = 0, c_max_v = 0;
    int c_vs_low = 0, c_vs_first = -1;
    int c_ff_cnt = 0, c_ff_first = -1, c_bad_col = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            c_pos = 0; c_fs_cnt = 0; c_fs_first = -1; c_fs_second = -1;
            c_max_h = 0; c_max_v = 0; c_vs_low = 0; c_vs_first = -1;
            c_ff_cnt = 0; c_ff_first = -1; c_bad_col = 0;
        end else begin
            c_pos++;
            if (c_pos <= 480) begin
                if (c_if.frame_start) begin
                    c_fs_cnt++;
                    if (c_fs_first < 0) c_fs_first = c_pos;
                    else if (c_fs_second < 0) c_fs_second = c_pos;
                end
                if (int'(c_if.addrh) > c_max_h) c_max_h = int'(c_if.addrh);
                if (int'(c_if.addrv) > c_max_v) c_max_v = int'(c_if.addrv);
                if (int'(c_if.colour_out) != 0 && int'(c_if.colour_out) != 255) c_bad_col++;
                if (c_pos <= 240) begin
                    if (!c_if.vs) begin
                        c_vs_low++;
                        if (c_vs_first < 0) c_vs_first = c_pos;
                    end
                    if (int'(c_if.colour_out) == 255) begin
                        c_ff_cnt++;
                        if (c_ff_first < 0) c_ff_first = c_pos;
                    end
                end
            end
        end
    end

    initial begin : main
        int pos;
        int a_fall;
        int b_fall;
        int s_h, s_v, s_c, s_hs, s_vs, s_fs;

        // dut 0: CLK_DIV 4 (tick edge 4n), dut 1: CLK_DIV 2 (tick edge 2n);
        // at tick n the pins show pixel n-2, colour = h ^ v ^ 0x3C when visible
        vecs[0]  = '{0,    4,   0, 0, 'h00, 1};
        vecs[1]  = '{1,    4,   1, 0, 'h3C, 1};
        vecs[2]  = '{1,    6,   2, 0, 'h3D, 1};
        vecs[3]  = '{0,    8,   1, 0, 'h3C, 1};
        vecs[4]  = '{0,   12,   2, 0, 'h3D, 1};
        vecs[5]  = '{0,   16,   3, 0, 'h3E, 1};
        vecs[6]  = '{1, 1314,   0, 0, 'h00, 1};
        vecs[7]  = '{1, 1316,   0, 0, 'h00, 0};
        vecs[8]  = '{0, 2564,   0, 0, 'h43, 1};
        vecs[9]  = '{0, 2568,   0, 0, 'h00, 1};
        vecs[10] = '{0, 2628,   0, 0, 'h00, 1};
        vecs[11] = '{0, 2632,   0, 0, 'h00, 0};
        vecs[12] = '{1, 2882,   0, 1, 'h42, 1};
        vecs[13] = '{1, 2914,   0, 1, 'h00, 1};
        vecs[14] = '{1, 2916,   0, 1, 'h00, 0};
        vecs[15] = '{0, 3012,   0, 0, 'h00, 0};
        vecs[16] = '{0, 3016,   0, 0, 'h00, 1};
        vecs[17] = '{0, 3204,   0, 1, 'h00, 1};
        vecs[18] = '{0, 3208,   1, 1, 'h3D, 1};
        vecs[19] = '{0, 3212,   2, 1, 'h3C, 1};
        vecs[20] = '{0, 4000, 199, 1, 'hFB, 1};
        vecs[21] = '{0, 5828,   0, 1, 'h00, 1};
        vecs[22] = '{0, 5832,   0, 1, 'h00, 0};
        vecs[23] = '{0, 6212,   0, 1, 'h00, 0};
        vecs[24] = '{0, 6216,   0, 1, 'h00, 1};

        repeat (3) @(negedge clk);
        chk("rst_addrh", int'(a_if.addrh), 0);
        chk("rst_addrv", int'(a_if.addrv), 0);
        chk("rst_colour", int'(a_if.colour_out), 0);
        chk("rst_hs", int'(a_if.hs), 1);
        chk("rst_vs", int'(a_if.vs), 1);
        chk("rst_frame_start", int'(a_if.frame_start), 0);

        rst = 1'b0;
        pos = 0;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].k > pos) begin
                repeat (vecs[i].k - pos) @(posedge clk);
                #1;
                pos = vecs[i].k;
            end
            if (vecs[i].dut == 0) begin
                s_h = int'(a_if.addrh); s_v = int'(a_if.addrv); s_c = int'(a_if.colour_out);
                s_hs = int'(a_if.hs); s_vs = int'(a_if.vs); s_fs = int'(a_if.frame_start);
            end else begin
                s_h = int'(b_if.addrh); s_v = int'(b_if.addrv); s_c = int'(b_if.colour_out);
                s_hs = int'(b_if.hs); s_vs = int'(b_if.vs); s_fs = int'(b_if.frame_start);
            end
            chk($sformatf("vec%0d_addrh", i), s_h, vecs[i].addrh);
            chk($sformatf("vec%0d_addrv", i), s_v, vecs[i].addrv);
            chk($sformatf("vec%0d_colour", i), s_c, vecs[i].colour);
            chk($sformatf("vec%0d_hs", i), s_hs, vecs[i].hs);
            chk($sformatf("vec%0d_vs", i), s_vs, 1);
            chk($sformatf("vec%0d_frame_start", i), s_fs, 0);
        end

        // Tiny frame: pulses at the 0,0 reload (tick 120), VS on lines 5..6, 32 visible pixels
        chk("c_fs_count", c_fs_cnt, 2);
        chk("c_fs_first", c_fs_first, 240);
        chk("c_fs_second", c_fs_second, 480);
        chk("c_max_addrh", c_max_h, 7);
        chk("c_max_addrv", c_max_v, 3);
        chk("c_vs_first_low", c_vs_first, 154);
        chk("c_vs_low_clks", c_vs_low, 60);
        chk("c_white_clks", c_ff_cnt, 64);
        chk("c_white_first", c_ff_first, 4);
        chk("c_stray_colour", c_bad_col, 0);

        // Mid-line async reset: unit A at hcnt=700 of line 2 with HS low
        repeat (9200 - pos) @(posedge clk);
        #1;
        chk("pre_rst_a_hs", int'(a_if.hs), 0);
        chk("pre_rst_a_addrv", int'(a_if.addrv), 2);
        chk("pre_rst_b_colour", int'(b_if.colour_out), 'h6F);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_a_hs", int'(a_if.hs), 1);
        chk("mid_rst_a_vs", int'(a_if.vs), 1);
        chk("mid_rst_a_colour", int'(a_if.colour_out), 0);
        chk("mid_rst_a_addrv", int'(a_if.addrv), 0);
        chk("mid_rst_b_colour", int'(b_if.colour_out), 0);
        chk("mid_rst_b_addrh", int'(b_if.addrh), 0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_fs", int'(a_if.frame_start | b_if.frame_start | c_if.frame_start), 0);

        // First HS fall after release: hcnt reaches 656 plus the two register stages
        rst = 1'b0;
        a_fall = -1;
        b_fall = -1;
        for (int e = 1; e <= 3000 && a_fall < 0; e++) begin
            @(posedge clk);
            #1;
            if (b_fall < 0 && !b_if.hs) b_fall = e;
            if (a_fall < 0 && !a_if.hs) a_fall = e;
        end
        chk("rel_a_first_hs_fall", a_fall, 4 * 658);
        chk("rel_b_first_hs_fall", b_fall, 2 * 658);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
